// File: rtl/multi_output_layer_ctrl.sv
// rtl/multi_output_layer_ctrl.sv - one-entry fork controller broadcasting an item to several consumers
module multi_output_layer_ctrl #(
    parameter int NUM_OUTPUTS = 2,
    parameter int WIDTH       = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    output logic                   en_o,
    output logic                   ready_o,
    input  logic                   valid_i,
    input  logic [WIDTH-1:0]       data_i,
    output logic [NUM_OUTPUTS-1:0] valid_o,
    input  logic [NUM_OUTPUTS-1:0] ready_i,
    output logic [WIDTH-1:0]       data_o
);

    typedef enum logic {
        eEMPTY = 1'b0,
        eFULL  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_OUTPUTS-1:0] pending_q, pending_d;
    logic [WIDTH-1:0]       data_q, data_d;

    logic last_w;
    logic ready_w;
    logic en_w;

    // Last transfer: every consumer still owed the item takes it this cycle,
    // which frees the register for a new item without a bubble.
    always_comb begin
        last_w  = (state_q == eFULL) && ((pending_q & ~ready_i) == '0);
        ready_w = (state_q == eEMPTY) || last_w;
        en_w    = ready_w && valid_i;
    end

    assign ready_o = ready_w;
    assign en_o    = en_w;
    assign valid_o = pending_q;
    assign data_o  = data_q;

    // Next state: load on accept, otherwise retire the consumers that took the item.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        data_d    = data_q;
        if (en_w) begin
            data_d    = data_i;
            pending_d = {NUM_OUTPUTS{1'b1}};
            state_d   = eFULL;
        end else if (state_q == eFULL) begin
            pending_d = pending_q & ~ready_i;
            state_d   = last_w ? eEMPTY : eFULL;
        end
    end

    // State, pending mask and data register; reset discards any item in flight.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= eEMPTY;
            pending_q <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            data_q    <= data_d;
        end
    end

endmodule

// File: tb/tb_multi_output_layer_ctrl.sv
// tb/tb_multi_output_layer_ctrl.sv - randomized self-checking bench for multi_output_layer_ctrl
module tb_multi_output_layer_ctrl;

    localparam int N = 2;
    localparam int W = 16;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         en_o;
    logic         ready_o;
    logic         valid_i;
    logic [W-1:0] data_i;
    logic [N-1:0] valid_o;
    logic [N-1:0] ready_i;
    logic [W-1:0] data_o;

    int checks   = 0;
    int failures = 0;

    // Reference model: is an item held, which consumers already got it, and its value.
    bit           m_have;
    bit [N-1:0]   m_served;
    logic [W-1:0] m_item;
    // Per-consumer list of items accepted upstream but not yet delivered.
    logic [W-1:0] sb [N][$];

    multi_output_layer_ctrl #(.NUM_OUTPUTS(N), .WIDTH(W)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_o    (en_o),
        .ready_o (ready_o),
        .valid_i (valid_i),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_have   = 1'b0;
        m_served = '0;
        m_item   = '0;
        for (int k = 0; k < N; k++) sb[k].delete();
    endtask

    // One clock cycle: drive inputs, compare against the model, then advance the model.
    task automatic step(input logic vi, input logic [W-1:0] di, input logic [N-1:0] rdy);
        logic [N-1:0] exp_valid;
        logic         exp_ready;
        logic [W-1:0] exp_item;
        int           left;
        @(negedge clk_i);
        valid_i = vi;
        data_i  = di;
        ready_i = rdy;
        #1;
        exp_valid = '0;
        for (int k = 0; k < N; k++)
            if (m_have && !m_served[k]) exp_valid[k] = 1'b1;
        left = 0;
        for (int k = 0; k < N; k++)
            if (exp_valid[k] && !rdy[k]) left++;
        exp_ready = !m_have || (left == 0);
        check("valid_o", valid_o, exp_valid);
        check("data_o", data_o, m_item);
        check("ready_o", ready_o, exp_ready);
        check("en_o", en_o, exp_ready && vi);
        for (int k = 0; k < N; k++) begin
            if (valid_o[k] && rdy[k]) begin
                if (sb[k].size() == 0) begin
                    check("xfer_unexpected", valid_o[k], 1'b0);
                end else begin
                    exp_item = sb[k].pop_front();
                    check("xfer_data", data_o, exp_item);
                end
            end
        end
        if (exp_ready && vi) begin
            m_have   = 1'b1;
            m_item   = di;
            m_served = '0;
            for (int k = 0; k < N; k++) sb[k].push_back(di);
        end else if (m_have) begin
            m_served = m_served | (exp_valid & rdy);
            if (&m_served) m_have = 1'b0;
        end
    endtask

    // Assert reset between clock edges and verify outputs clear without a clock.
    task automatic mid_reset();
        @(negedge clk_i);
        valid_i = 1'b0;
        ready_i = '0;
        #2 reset_i = 1'b1;
        #1;
        check("rst_valid_o", valid_o, 0);
        check("rst_data_o", data_o, 0);
        @(negedge clk_i);
        reset_i = 1'b0;
        model_clear();
    endtask

    initial begin
        logic [N-1:0] rdy;
        int           bias;
        reset_i = 1'b1;
        valid_i = 1'b0;
        data_i  = '0;
        ready_i = '0;
        model_clear();
        #2;
        check("init_valid_o", valid_o, 0);
        check("init_data_o", data_o, 0);
        @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        check("idle_ready_o", ready_o, 1);
        check("idle_en_o", en_o, 0);

        // Streaming with all consumers ready: one item per cycle.
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, W'(i), 2'b11);
            check("stream_ready_o", ready_o, 1);
            if (i > 1) check("stream_data_o", data_o, i - 1);
        end
        step(1'b0, '0, 2'b11);
        check("stream_last_valid", valid_o, 2'b11);
        check("stream_last_data", data_o, 16'h0004);

        // Staggered acceptance.
        step(1'b1, 16'hBEEF, 2'b00);
        step(1'b0, '0, 2'b01);
        check("stag_v0", valid_o, 2'b11);
        check("stag_r0", ready_o, 0);
        step(1'b0, '0, 2'b00);
        check("stag_v1", valid_o, 2'b10);
        check("stag_r1", ready_o, 0);
        step(1'b0, '0, 2'b00);
        check("stag_v2", valid_o, 2'b10);
        step(1'b0, '0, 2'b10);
        check("stag_v3", valid_o, 2'b10);
        check("stag_r3", ready_o, 1);
        step(1'b0, '0, 2'b00);
        check("stag_v4", valid_o, 2'b00);

        // Stalled consumer 1 with upstream pushing, then load on last transfer.
        step(1'b1, 16'hA5A5, 2'b00);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, W'($urandom), 2'b01);
            check("stall_ready_o", ready_o, 0);
            check("stall_en_o", en_o, 0);
            check("stall_data_o", data_o, 16'hA5A5);
        end
        step(1'b1, 16'h1234, 2'b10);
        check("lol_en_o", en_o, 1);
        step(1'b0, '0, 2'b00);
        check("lol_valid_o", valid_o, 2'b11);
        check("lol_data_o", data_o, 16'h1234);

        // Reset with consumer 1 still pending.
        step(1'b0, '0, 2'b01);
        check("pre_rst_valid", valid_o, 2'b11);
        mid_reset();
        step(1'b1, 16'h0F0F, 2'b00);
        step(1'b0, '0, 2'b00);
        check("post_rst_valid", valid_o, 2'b11);
        check("post_rst_data", data_o, 16'h0F0F);

        // Randomized traffic with varying consumer readiness.
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) bias = $urandom_range(1, 9);
            for (int k = 0; k < N; k++) rdy[k] = ($urandom_range(0, 9) < bias);
            step($urandom_range(0, 2) != 0, W'($urandom), rdy);
        end

        // Drain and confirm nothing was lost.
        for (int i = 0; i < 4; i++) step(1'b0, '0, '1);
        for (int k = 0; k < N; k++) check("drain_empty", sb[k].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_output_layer_ctrl.md
Name: multi_output_layer_ctrl

Overview:
- Fork controller with a one-entry data register. It takes one item from a single upstream layer over valid/ready and broadcasts it to NUM_OUTPUTS downstream layers, each of which has its own valid/ready pair.
- A consumer that has already taken the item is not offered it again. The next item is loaded only once every consumer has taken the current one, or takes it in the same cycle.
- It is the mirror of the multi-input join controller: it sits where one layer's result feeds several parallel layers.

Parameters:
- NUM_OUTPUTS, 2, number of downstream consumers (>=1)
- WIDTH, 16, data width in bits

Ports:
- clk_i  input  1  clock
- reset_i  input  1  asynchronous, active-high reset
- en_o  output  1  load strobe, asserted when an item is consumed from upstream this cycle
- ready_o  output  1  handshake to previous layer; block can accept an item
- valid_i  input  1  handshake from previous layer; data_i is valid
- data_i  input  WIDTH  item from previous layer
- valid_o  output  NUM_OUTPUTS  per-consumer valid; bit k means data_o is pending for consumer k
- ready_i  input  NUM_OUTPUTS  per-consumer ready
- data_o  output  WIDTH  registered broadcast data, common to all consumers

Behaviour:
- Interface role: demanding consumer upstream, helpful producer downstream.
- valid_o and data_o come directly from registers. ready_o may depend combinationally on ready_i and state.
- State:
  - state_r in {eEMPTY, eFULL}
  - pending_r[NUM_OUTPUTS-1:0]
  - data_r[WIDTH-1:0]
- Reset (asynchronous, effective immediately while reset_i=1):
  - state_r=eEMPTY, pending_r=0, data_r=0
  - Hence valid_o=0, data_o=0, and ready_o=1 once reset is released.
- Outputs:
  - valid_o = pending_r (all zero in eEMPTY)
  - data_o = data_r
- Transfers:
  - A transfer to consumer k occurs when valid_o[k] && ready_i[k].
  - last = (state_r==eFULL) && ((pending_r & ~ready_i) == 0)
  - ready_o = (state_r==eEMPTY) || last
  - en_o = ready_o && valid_i
- Next state:
  - If en_o: data_r<=data_i, pending_r<=all ones, state_r<=eFULL.
  - Else if eFULL: pending_r<=pending_r & ~ready_i; state_r<=eEMPTY if last, otherwise stays eFULL.
  - Else (eEMPTY, no valid_i): hold.
- Latency and throughput:
  - Item accepted in cycle t is presented on valid_o in cycle t+1.
  - Full throughput of one item per cycle when all ready_i=1 every cycle.
- Boundary conditions:
  - Simultaneous last transfer and upstream valid: new item loads in the same cycle, with no empty bubble.
  - ready_i[k] asserted while valid_o[k]=0 (consumer already served, or block empty): ignored, no effect on state.
  - Staggered acceptance: each consumer sees exactly one valid/ready transfer per item; valid_o[k] drops the cycle after consumer k's transfer.
  - Stalled consumer: pending bits stay set, data_r stays stable, and ready_o=0 until the stalled consumer accepts.
  - Reset asserted mid-item: the pending item is discarded and all outputs clear asynchronously.
- NUM_OUTPUTS=1: the block degenerates to a single-element pipeline register with the same timing.

Test Plan:
- Reset then idle: assert reset_i asynchronously mid-cycle -> valid_o=00 and data_o=0 immediately; after release ready_o=1, en_o=0.
- Broadcast with all consumers ready: NUM_OUTPUTS=2, ready_i=11, stream 0x0001..0x0004 on consecutive cycles -> each item on data_o one cycle later with valid_o=11, ready_o=1 throughout, 4 items in 4 cycles.
- Staggered accept: load 0xBEEF; ready_i=01 for one cycle, then 00 for two cycles, then 10 -> valid_o goes 11, 10, 10, 10, then 00. Consumer 0 gets one transfer, consumer 1 gets one transfer. ready_o=1 only in the ready_i=10 cycle.
- Load on last transfer: valid_o=10, ready_i=10, valid_i=1 with data_i=0x1234 in the same cycle -> en_o=1; next cycle valid_o=11 and data_o=0x1234, with no bubble.
- Stalled consumer backpressure: consumer 1 holds ready_i[1]=0 for 5 cycles with valid_i=1 and data_i changing every cycle -> ready_o=0, en_o=0, data_o unchanged for all 5 cycles; no item lost or duplicated once it releases.
- Reset mid-item: valid_o=10 pending, pulse reset_i -> valid_o=00 immediately; the next upload is delivered with valid_o=11.
